mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between instruction fetch (IF) and data load/store (D).
- Replaces the hard-coded fetch/wait-wait sequence in the control unit. Each requester issues a req/gnt/done transaction, and the arbiter inserts the memory wait states itself.
- Sits between the control unit / datapath and the memory; it owns the address, write-data and MemReadWrite signals to memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- READ_LAT, 2, memory cycles a read address must be held before mem_rdata is valid (≥1).
- WRITE_LAT, 1, memory cycles a write must be held (≥1).
- RR_EN, 1, 1 = alternate priority on conflict; 0 = D always wins over IF.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address; sampled in the if_gnt cycle.
- if_gnt  out  1  one-cycle combinational grant to IF.
- if_done  out  1  one-cycle pulse; rdata holds the instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load; sampled with d_gnt.
- d_addr  in  ADDR_W  data address; sampled with d_gnt.
- d_wdata  in  DATA_W  store data; sampled with d_gnt.
- d_gnt  out  1  one-cycle combinational grant to D.
- d_done  out  1  one-cycle pulse at completion of a load or store.
- rdata  out  DATA_W  registered read data; valid in the done cycle, held until the next read completes.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_wr  out  1  MemReadWrite: 1 = write, 0 = read.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 whenever state ≠ IDLE.
- owner  out  1  0 = IF, 1 = D; owner of the current or most recent access.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE, counter = 0, last_owner = IF.
  - All outputs 0: gnt, done, mem_wr, mem_addr, mem_wdata, rdata, busy, owner.
  - An in-flight access is abandoned and no done is issued. reset is released synchronously internally only if the implementation chooses; the assert edge is always asynchronous.
- States: IDLE → ACCESS → DONE → IDLE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If only one req is high, that requester wins.
  - If both are high and RR_EN=1, the winner is the requester ≠ last_owner.
  - If both are high and RR_EN=0, D wins.
  - In the same cycle: assert winner's gnt (combinational); latch addr/we/wdata into mem_addr/mem_wr/mem_wdata; set owner and last_owner.
  - IF accesses always have mem_wr=0.
  - Load counter with (mem_wr ? WRITE_LAT : READ_LAT) − 1; next state = ACCESS.
- ACCESS:
  - mem_addr, mem_wdata and mem_wr are held stable; counter decrements each cycle.
  - When counter==0: for a read, capture mem_rdata into rdata; next state = DONE.
- DONE:
  - Assert owner's done for exactly one cycle.
  - mem_wr returns to 0 on entry to DONE.
  - No grant is issued in DONE; next state = IDLE.
- Latency:
  - gnt cycle t, done at t+LAT+1.
  - With READ_LAT=2: gnt t, ACCESS t+1 and t+2, done t+3.
  - Back-to-back throughput: one access per LAT+2 cycles.
- Requester rules:
  - req asserted while busy is ignored until IDLE.
  - A req still high in the cycle after done counts as a new request.
  - Address and data may change after gnt without effect.
- Simultaneous events: a loser's req stays pending and is served at the next IDLE. With RR_EN=1, continuous conflict alternates D, IF, D, IF…
- rdata is not updated by writes.
- Parameter checks: READ_LAT=0 or WRITE_LAT=0 is an elaboration-time error.

Decomposition:
- Package mem_arb_pkg:
  - enum arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_DONE}.
  - enum owner_t {OWN_IF=0, OWN_D=1}.
  - Pure function pick_winner(if_req, d_req, last_owner, rr_en).
- No sub-module: the FSM, counter and latches form a single module of roughly 150–200 lines.

Test Plan:
- Reset: hold reset=0 with both reqs high → all outputs 0 and no gnt. Release → d_gnt in the first cycle, since last_owner=IF.
- Single fetch: if_req=1, if_addr=0x0000_0040, memory returns 0x8C22_0004 → if_gnt at t, mem_addr=0x40 at t+1..t+2, if_done with rdata=0x8C22_0004 at t+3, mem_wr=0 throughout.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF (WRITE_LAT=1) → mem_wr=1 at t+1 only, d_done at t+2, rdata unchanged.
- Conflict, RR_EN=1: both reqs held high for 4 transactions → grant order D, IF, D, IF, each 4 cycles apart with READ_LAT=2. With RR_EN=0 → D, D, D, D.
- Mid-operation reset: reset=0 at t+2 of a read → busy=0 and no done at t+3. After release, the pending if_req is granted afresh.
- Address change after grant: alter if_addr to 0x44 at t+1 → mem_addr stays 0x40 until done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and the arbitration rule for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
  function automatic owner_t pick_winner(input logic if_req, input logic d_req, input owner_t last_owner, input logic rr_en);
    return !d_req ? OWN_IF : !if_req ? OWN_D : (rr_en && last_owner == OWN_D) ? OWN_IF : OWN_D;
  endfunction
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1,
  parameter int RR_EN     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam int MAXL = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
  localparam int CW = MAXL > 1 ? $clog2(MAXL) : 1;
  if (READ_LAT < 1 || WRITE_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: READ_LAT and WRITE_LAT must be at least 1");
  end
  arb_state_t state, state_nxt;
  owner_t win, owner_q;
  logic [CW-1:0] cnt;
  logic grant, cnt_zero, d_write;
  assign win = pick_winner(if_req, d_req, owner_q, RR_EN != 0);
  // grant is gated by reset so no requester sees a grant while the port is held in reset
  assign grant = reset && state == ARB_IDLE && (if_req || d_req);
  assign if_gnt = grant && win == OWN_IF;
  assign d_gnt = grant && win == OWN_D;
  assign if_done = state == ARB_DONE && owner_q == OWN_IF;
  assign d_done = state == ARB_DONE && owner_q == OWN_D;
  assign busy = state != ARB_IDLE;
  assign owner = owner_q;
  assign cnt_zero = cnt == '0;
  assign d_write = win == OWN_D && d_we;
  always_comb begin
    state_nxt = state;
    state_nxt = grant ? ARB_ACCESS :
                (state == ARB_ACCESS && cnt_zero) ? ARB_DONE :
                state == ARB_DONE ? ARB_IDLE : state;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      owner_q   <= OWN_IF;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_q  <= win;
        mem_addr <= win == OWN_D ? d_addr : if_addr;
        mem_wr   <= d_write;
        cnt      <= d_write ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
        if (win == OWN_D) mem_wdata <= d_wdata;
      end else if (state == ARB_ACCESS) begin
        if (cnt_zero) begin
          mem_wr <= 1'b0;
          if (!mem_wr) rdata <= mem_rdata;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tables plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam logic [31:0] K = 32'h8C22_0044;
  logic clock = 1'b0, reset = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic if_gnt, if_done, d_gnt, d_done, mem_wr, busy, owner;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_gnt1, if_done1, d_gnt1, d_done1, mem_wr1, busy1, owner1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  int n_pass = 0, n_chk = 0;

  assign mem_rdata = mem_addr ^ K;
  assign mem_rdata1 = mem_addr1 ^ K;
  always #5 clock = ~clock;

  mem_port_arbiter #(.RR_EN(1)) dut (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner));

  mem_port_arbiter #(.RR_EN(0)) dut_fixed (
    .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_done(if_done1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt1), .d_done(d_done1),
    .rdata(rdata1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1), .mem_rdata(mem_rdata1),
    .busy(busy1), .owner(owner1));

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int g, lat, free;
    logic m_own, m_we, idle, in_acc, done_c, gx, w, ip, dp;
    logic [31:0] m_addr, exp_rd;
    tbl[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h8C22_0004};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h8C22_0004};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'h8C22_2044};
    tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h73DD_FFB8};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_1234, 32'h73DD_FFB8};

    // reset held with both requests pending
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h10; d_addr = 32'h20;
    repeat (3) tick();
    #3;
    chk("rst_gnt", {if_gnt, d_gnt}, 2'b00);
    chk("rst_done", {if_done, d_done}, 2'b00);
    chk("rst_busy_owner_wr", {busy, owner, mem_wr}, 3'b000);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    tick();
    reset = 1'b1;
    // continuous conflict: RR alternates D,IF,..., fixed priority always D
    for (int k = 0; k < 16; k++) begin
      #3;
      chk($sformatf("conflict_gnt_k%0d", k), {d_gnt, if_gnt, d_gnt1, if_gnt1},
          (k % 4 != 0) ? 4'b0000 : ((k / 4) % 2 == 0) ? 4'b1010 : 4'b0110);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;

    // single transactions, with address/data changed right after grant
    for (int i = 0; i < 5; i++) begin
      int tl;
      tl = tbl[i].we ? 1 : 2;
      if_req = !tbl[i].is_d; d_req = tbl[i].is_d; d_we = tbl[i].we;
      if_addr = tbl[i].addr; d_addr = tbl[i].addr; d_wdata = tbl[i].wdata;
      #3;
      chk($sformatf("tbl%0d_gnt", i), {if_gnt, d_gnt}, {!tbl[i].is_d, tbl[i].is_d});
      tick();
      if_req = 1'b0; d_req = 1'b0; d_we = !tbl[i].we;
      if_addr = tbl[i].addr + 4; d_addr = tbl[i].addr + 4; d_wdata = ~tbl[i].wdata;
      for (int k = 1; k <= tl + 1; k++) begin
        #3;
        chk($sformatf("tbl%0d_k%0d_mem_addr", i, k), mem_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_k%0d_mem_wr", i, k), mem_wr, tbl[i].we && k <= tl);
        chk($sformatf("tbl%0d_k%0d_busy_owner", i, k), {busy, owner}, {1'b1, tbl[i].is_d});
        chk($sformatf("tbl%0d_k%0d_done", i, k), {if_done, d_done},
            {!tbl[i].is_d && k == tl + 1, tbl[i].is_d && k == tl + 1});
        if (tbl[i].we && k == 1) chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].wdata);
        if (k == tl + 1) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
        tick();
      end
    end

    // reset in the middle of a read abandons it; the held request is granted afresh
    if_req = 1'b1; if_addr = 32'h80;
    #3;
    chk("midrst_first_gnt", if_gnt, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    #3;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_no_gnt", {if_gnt, d_gnt}, 2'b00);
    tick();
    #3;
    chk("midrst_no_done", {if_done, d_done, busy}, 3'b000);
    tick();
    reset = 1'b1;
    #3;
    chk("midrst_regrant", if_gnt, 1'b1);
    tick();
    if_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #3;
      chk($sformatf("midrst_done_k%0d", k), if_done, k == 3);
      if (k == 3) chk("midrst_done_rdata", rdata, 32'h8C22_00C4);
      tick();
    end

    // randomized traffic against a transaction-timeline model
    exp_rd = 32'h8C22_00C4; m_own = 1'b0; m_we = 1'b0; m_addr = '0;
    g = -100; lat = 0; free = 0; ip = 1'b0; dp = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!ip) begin if_req = 1'($urandom_range(0, 1)); if_addr = $urandom; end
      if (!dp) begin d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom; end
      #3;
      idle = c >= free;
      in_acc = c > g && c <= g + lat;
      done_c = c == g + lat + 1;
      if (done_c && !m_we) exp_rd = m_addr ^ K;
      chk($sformatf("rnd%0d_busy_owner", c), {busy, owner}, {!idle, m_own});
      chk($sformatf("rnd%0d_mem_wr", c), mem_wr, in_acc && m_we);
      chk($sformatf("rnd%0d_done", c), {if_done, d_done}, {done_c && !m_own, done_c && m_own});
      if (in_acc || done_c) chk($sformatf("rnd%0d_mem_addr", c), mem_addr, m_addr);
      chk($sformatf("rnd%0d_rdata", c), rdata, exp_rd);
      gx = idle && (if_req || d_req);
      w = !d_req ? 1'b0 : !if_req ? 1'b1 : !m_own;
      chk($sformatf("rnd%0d_gnt", c), {if_gnt, d_gnt}, {gx && !w, gx && w});
      if (gx) begin
        g = c; m_own = w; m_addr = w ? d_addr : if_addr; m_we = w && d_we;
        lat = m_we ? 1 : 2; free = c + lat + 2;
      end
      ip = if_req && !(gx && !w);
      dp = d_req && !(gx && w);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
